swap_sequencer: RTL and testbench
=================================

Name: swap_sequencer

Overview:
- Initiator for the swap port of the team's swap register file.
- Given a base address and a length, it reverses that block of the register file in place.
- It does this by issuing a sequence of swap requests on pairs (lo, hi) and waits for each swap to be acknowledged before issuing the next.
- Sits between control logic (or a test FSM) and the register file's address_A/address_B/swap inputs.

Parameters:
- ADDR_WIDTH, 7, width of register-file addresses.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin a reversal; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of the block.
- length  in  ADDR_WIDTH+1  number of locations in the block, 0..2^ADDR_WIDTH.
- swap_done  in  1  one-cycle acknowledge from the register file: the current swap has completed.
- address_A  out  ADDR_WIDTH  low address of the current pair (registered).
- address_B  out  ADDR_WIDTH  high address of the current pair (registered).
- swap  out  1  swap request to the register file (registered, level).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the reversal finishes.
- swap_count  out  ADDR_WIDTH  swaps completed in the current or last operation.

Behaviour:
- Reset values: state=IDLE; swap=0, done=0, busy=0, address_A=0, address_B=0, swap_count=0. Internal remaining counter is also 0.
- States: IDLE, ISSUE, GAP, FINISH.
- IDLE with start=1 and length>=2, at the edge:
  - address_A<=base_addr; address_B<=base_addr+length-1, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - remaining<=length>>1; swap_count<=0; swap<=1; go to ISSUE.
  - swap is therefore high in the first cycle after start.
- IDLE with start=1 and length<2: swap_count<=0; go to FINISH. No swap is issued.
- ISSUE: swap held at 1 and addresses held stable until swap_done=1 is sampled. On that edge:
  - swap<=0; swap_count+=1; remaining-=1.
  - If remaining was 1, go to FINISH.
  - Otherwise address_A<=address_A+1 and address_B<=address_B-1 (both wrap), then go to GAP.
- GAP: exactly one cycle with swap=0. Then swap<=1 and go to ISSUE. This guarantees the responder sees a fresh request for every pair.
- FINISH: done=1 for exactly one cycle, then IDLE. Addresses and swap_count keep their last values.
- Termination uses the remaining counter, never an address comparison, so wrap-around blocks work.
- Number of swaps is always floor(length/2); the middle element of an odd length is untouched.
- length=2^ADDR_WIDTH (MSB set) is legal: pairs span the whole file, 2^(ADDR_WIDTH-1) swaps.
- start is ignored in ISSUE, GAP and FINISH. base_addr and length are sampled only at the accepting edge.
- swap_done outside ISSUE is ignored.
- swap_done arriving in the same cycle swap rises is accepted; the minimum cycles per pair is 2 (ISSUE + GAP).
- reset mid-operation takes priority over all else. swap drops and state returns to IDLE at the reset edge, with no done pulse.
- No timeout: if swap_done never arrives, the block stays in ISSUE.

Test Plan:
- Fill file[i]=i for 20..29. Pulse start with base=20, length=10; the bench model acks one cycle after swap rises.
  -> Pairs (20,29),(21,28),(22,27),(23,26),(24,25) in order; swap low exactly one cycle between pairs.
  -> done pulses once; swap_count=5; file[20..29]=29..20.
- base=10, length=5 -> pairs (10,14),(11,13); swap_count=2; file[12] unchanged.
- base=126, length=4 (ADDR_WIDTH=7) -> pairs (126,1),(127,0); swap_count=2; done once.
- length=1 and length=0 -> swap never asserted; done one cycle after the start edge is followed by one FINISH cycle; swap_count=0.
- Ack delayed 4 cycles per pair -> addresses stable and swap high throughout the wait. A start pulsed mid-operation is ignored, leaving operation results identical.
- Assert reset during the third ISSUE of the base=20/length=10 run -> swap=0, busy=0, done never pulses. A new start then begins afresh from base_addr with swap_count=0.

Source files
------------

// File: rtl/swap_sequencer.sv
// Reverses a block of the swap register file in place by issuing swap
// requests on (lo, hi) address pairs, one pair per acknowledge.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold results of last operation
// ISSUE  | swap request held high until swap_done is sampled
// GAP    | one cycle with swap low so every pair is a fresh request
// FINISH | done pulse, then back to IDLE
module swap_sequencer #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  swap_done,
  output logic [ADDR_WIDTH-1:0] address_A,
  output logic [ADDR_WIDTH-1:0] address_B,
  output logic                  swap,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] swap_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_L = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   TWO_L = (ADDR_WIDTH + 1)'(2);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH:0]   last_addr;

  // Upper address of the first pair; the carry bit is dropped so blocks wrap.
  assign last_addr = {1'b0, base_addr} + length - ONE_L;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      address_A  <= '0;
      address_B  <= '0;
      swap       <= 1'b0;
      done       <= 1'b0;
      swap_count <= '0;
      remaining  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            swap_count <= '0;
            if (length >= TWO_L) begin
              address_A <= base_addr;
              address_B <= last_addr[ADDR_WIDTH-1:0];
              remaining <= length[ADDR_WIDTH:1];
              swap      <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              done  <= 1'b1;
              state <= S_FINISH;
            end
          end
        end
        S_ISSUE: begin
          if (swap_done) begin
            swap       <= 1'b0;
            swap_count <= swap_count + ONE_A;
            remaining  <= remaining - ONE_A;
            // Termination counts pairs rather than comparing addresses, so
            // blocks that wrap past the top of the file finish correctly.
            if (remaining == ONE_A) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              address_A <= address_A + ONE_A;
              address_B <= address_B - ONE_A;
              state     <= S_GAP;
            end
          end
        end
        S_GAP: begin
          swap  <= 1'b1;
          state <= S_ISSUE;
        end
        S_FINISH: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          swap  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swap_sequencer.sv
// Scoreboard bench for swap_sequencer: a register-file responder, expected
// pair/count queues filled at stimulus time, and a monitor that pops them.
module tb_swap_sequencer;
  localparam int AW = 7;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          swap_done;
  logic [AW-1:0] address_A;
  logic [AW-1:0] address_B;
  logic          swap;
  logic          busy;
  logic          done;
  logic [AW-1:0] swap_count;

  swap_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .swap_done  (swap_done),
    .address_A  (address_A),
    .address_B  (address_B),
    .swap       (swap),
    .busy       (busy),
    .done       (done),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int idx;
  } pair_t;

  pair_t exp_pairs[$];
  int    exp_counts[$];
  int    rf[N];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ack_delay = 1;
  bit    noise = 1'b0;
  int    rsp_wait = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Register-file model: swaps its contents when it acknowledges a request.
  initial begin : responder
    int t;
    swap_done = 1'b0;
    forever begin
      @(negedge clk);
      if (swap === 1'b1 && reset !== 1'b1) begin
        if (rsp_wait >= ack_delay) begin
          swap_done = 1'b1;
          t = rf[address_A];
          rf[address_A] = rf[address_B];
          rf[address_B] = t;
          rsp_wait = 0;
        end else begin
          swap_done = 1'b0;
          rsp_wait++;
        end
      end else begin
        swap_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        rsp_wait = 0;
      end
    end
  end

  initial begin : monitor
    logic          prev_swap;
    logic          prev_done;
    logic [AW-1:0] prev_a;
    logic [AW-1:0] prev_b;
    int            low_cycles;
    pair_t         p;
    prev_swap  = 1'b0;
    prev_done  = 1'b0;
    prev_a     = '0;
    prev_b     = '0;
    low_cycles = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        prev_swap  = 1'b0;
        prev_done  = 1'b0;
        low_cycles = 0;
      end else begin
        if (swap && !prev_swap) begin
          if (exp_pairs.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_swap: swap rose with A=%0d B=%0d, none expected", address_A, address_B);
          end else begin
            p = exp_pairs.pop_front();
            check("pair_A", int'(address_A), p.a);
            check("pair_B", int'(address_B), p.b);
            if (p.idx > 0) check("gap_cycles", low_cycles, 1);
          end
        end else if (swap && prev_swap) begin
          check("hold_A", int'(address_A), int'(prev_a));
          check("hold_B", int'(address_B), int'(prev_b));
        end
        if (swap) begin
          check("busy_with_swap", int'(busy), 1);
          low_cycles = 0;
        end else begin
          low_cycles++;
        end
        if (done) begin
          if (prev_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_width: done high for more than one cycle");
          end else if (exp_counts.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: done pulsed with swap_count=%0d, none expected", swap_count);
          end else begin
            check("swap_count", int'(swap_count), exp_counts.pop_front());
            check("swap_in_done", int'(swap), 0);
            check("busy_in_done", int'(busy), 1);
          end
        end
        prev_swap = swap;
        prev_done = done;
        prev_a    = address_A;
        prev_b    = address_B;
      end
    end
  end

  task automatic run_op(input int base, input int len, input int delay, input bit mid_start);
    int snap[N];
    int expf[N];
    int npairs;
    bit got;
    bit pulsed;
    npairs = len / 2;
    snap = rf;
    expf = rf;
    for (int k = 0; k < len; k++) expf[(base + k) % N] = snap[(base + len - 1 - k) % N];
    for (int k = 0; k < npairs; k++) begin
      pair_t p;
      p.a = (base + k) % N;
      p.b = (base + len - 1 - k) % N;
      p.idx = k;
      exp_pairs.push_back(p);
    end
    exp_counts.push_back(npairs);
    ack_delay = delay;
    @(posedge clk); #1;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    length    = (AW + 1)'($urandom);
    check("start_count_clear", int'(swap_count), 0);
    check("start_busy", int'(busy), 1);
    check("start_swap", int'(swap), int'(len >= 2));
    check("start_done", int'(done), int'(len < 2));
    got    = done;
    pulsed = 1'b0;
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      if (mid_start && !pulsed && swap && cyc >= 1) begin
        start     = 1'b1;
        base_addr = AW'($urandom);
        length    = (AW + 1)'($urandom_range(2, N));
        pulsed    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", int'(got), 1);
    for (int i = 0; i < N; i++) check("file_word", rf[i], expf[i]);
    @(posedge clk); #1;
    check("idle_after_finish", int'(busy), 0);
    check("done_low_after", int'(done), 0);
  endtask

  task automatic reset_test();
    int rises;
    bit prev;
    rises = 0;
    prev  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pair_t p;
      p.a = 20 + k;
      p.b = 29 - k;
      p.idx = k;
      exp_pairs.push_back(p);
    end
    exp_counts.push_back(5);
    ack_delay = 3;
    @(posedge clk); #1;
    base_addr = AW'(20);
    length    = (AW + 1)'(10);
    start     = 1'b1;
    for (int cyc = 0; cyc < 500 && rises < 3; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (swap && !prev) rises++;
      prev = swap;
    end
    check("third_issue_reached", rises, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_swap", int'(swap), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(swap_count), 0);
    check("rst_addr_A", int'(address_A), 0);
    exp_pairs.delete();
    exp_counts.delete();
    repeat (10) @(posedge clk);
    #1;
    check("rst_stays_idle", int'(busy), 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int len;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < N; i++) rf[i] = i;
    repeat (3) @(posedge clk);
    #1;
    check("reset_swap", int'(swap), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_A", int'(address_A), 0);
    check("reset_B", int'(address_B), 0);
    check("reset_count", int'(swap_count), 0);
    reset = 1'b0;

    run_op(20, 10, 1, 1'b0);
    run_op(10, 5, 1, 1'b0);
    run_op(126, 4, 1, 1'b0);
    run_op(40, 1, 1, 1'b0);
    run_op(50, 0, 1, 1'b0);
    run_op(20, 10, 4, 1'b1);
    run_op(0, N, 0, 1'b0);
    reset_test();
    run_op(20, 10, 1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      base = $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) == 0) len = $urandom_range(N - 3, N);
      else len = $urandom_range(0, 20);
      noise = 1'($urandom_range(0, 1));
      run_op(base, len, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    noise = 1'b0;

    repeat (3) @(posedge clk);
    check("pairs_left", exp_pairs.size(), 0);
    check("counts_left", exp_counts.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
